// File: rtl/enemy_column.sv
// One column of five invaders: alive flags, shared formation offset/direction, bullet hits,
// score, game-over and a 1-bit pixel. Define ENEMY_SPRITE_EN for animated bitmaps instead of solid boxes.
module enemy_column #(
    parameter int ENEMY_W     = 11,
    parameter int ENEMY_H     = 8,
    parameter int ROW_PITCH   = 12,
    parameter int STEP        = 2,
    parameter int DROP        = 8,
    parameter int MOVE_FRAMES = 8,
    parameter int LEFT_LIMIT  = 2,
    parameter int RIGHT_LIMIT = 317,
    parameter int GG_Y        = 200,
    parameter int TICK_X      = 240,
    parameter int TICK_Y      = 180
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        left_in,
    input  logic        right_in,
    input  logic [9:0]  sx,
    input  logic [8:0]  sy,
    input  logic [9:0]  vga_x,
    input  logic [8:0]  vga_y,
    input  logic [9:0]  bx,
    input  logic [8:0]  by,
    output logic        left,
    output logic        right,
    output logic        b_hit,
    output logic        move,
    output logic        pixel,
    output logic [10:0] score,
    output logic        gg
);
    localparam int FW = (MOVE_FRAMES > 1) ? $clog2(MOVE_FRAMES) : 1;
    localparam logic [FW-1:0]     FC_LAST  = FW'(MOVE_FRAMES - 1);
    localparam logic signed [11:0] W_M1    = 12'(ENEMY_W - 1);
    localparam logic signed [11:0] H_M1    = 12'(ENEMY_H - 1);
    localparam logic signed [11:0] STEP_S  = 12'(STEP);
    localparam logic [9:0]         DROP_U  = 10'(DROP);
    localparam logic signed [11:0] RLIM_S  = 12'(RIGHT_LIMIT);
    localparam logic signed [11:0] LLIM_S  = 12'(LEFT_LIMIT + STEP);
    localparam logic signed [11:0] GG_S    = 12'(GG_Y);

    logic signed [11:0] xoff_q, xoff_d;
    logic [9:0]         yoff_q, yoff_d;
    logic               dir_left_q, dir_left_d;
    logic [4:0]         alive_q, alive_d;
    logic [FW-1:0]      fcnt_q, fcnt_d;
    logic [10:0]        score_q, score_d;
    logic               at_tick_q;
    logic               b_hit_q, b_hit_d;
    logic               move_q, move_d;
    logic               pixel_q, pixel_d;
    logic               gg_q, gg_d;
`ifdef ENEMY_SPRITE_EN
    logic               anim_q, anim_d;
`endif

    logic signed [11:0] x_lo, x_hi, bx_s, by_s, vx_s, vy_s;
    logic signed [11:0] y_lo [5];
    logic [4:0]         hit_vec, scan_vec, low_vec;
    logic               at_tick, tick, any_alive, bullet_on;

    function automatic logic [10:0] row_points(input int row);
        if (row == 0)     return 11'd30;
        else if (row < 3) return 11'd20;
        else              return 11'd10;
    endfunction

`ifdef ENEMY_SPRITE_EN
    // Rows 6-7 carry the animation difference; bit 0 is the leftmost pixel.
    function automatic logic [10:0] sprite_row(input logic [1:0] kind, input logic frame,
                                               input logic [2:0] r);
        logic [10:0] row;
        row = '0;
        case (kind)
            2'd0: case (r)
                3'd0: row = 11'b00001110000;
                3'd1: row = 11'b00011111000;
                3'd2: row = 11'b00111111100;
                3'd3: row = 11'b01101110110;
                3'd4: row = 11'b01111111110;
                3'd5: row = 11'b00010001000;
                3'd6: row = frame ? 11'b00100000100 : 11'b00101110100;
                default: row = frame ? 11'b00010001000 : 11'b01010001010;
            endcase
            2'd1: case (r)
                3'd0: row = 11'b00100000100;
                3'd1: row = 11'b00010001000;
                3'd2: row = 11'b00111111100;
                3'd3: row = 11'b01101110110;
                3'd4: row = 11'b11111111111;
                3'd5: row = 11'b10111111101;
                3'd6: row = frame ? 11'b00100000100 : 11'b10100000101;
                default: row = frame ? 11'b01000000010 : 11'b00011011000;
            endcase
            default: case (r)
                3'd0: row = 11'b00011111000;
                3'd1: row = 11'b01111111110;
                3'd2: row = 11'b11111111111;
                3'd3: row = 11'b11100100111;
                3'd4: row = 11'b11111111111;
                3'd5: row = 11'b00111011100;
                3'd6: row = frame ? 11'b01101110110 : 11'b01100100110;
                default: row = frame ? 11'b11000000011 : 11'b00110001100;
            endcase
        endcase
        return row;
    endfunction
`endif

    assign bx_s      = $signed({2'b00, bx});
    assign by_s      = $signed({3'b000, by});
    assign vx_s      = $signed({2'b00, vga_x});
    assign vy_s      = $signed({3'b000, vga_y});
    assign x_lo      = $signed({2'b00, sx}) + xoff_q;
    assign x_hi      = x_lo + W_M1;
    assign any_alive = |alive_q;
    assign bullet_on = (bx != 10'd0) || (by != 9'd0);
    assign at_tick   = (vga_x == 10'(TICK_X)) && (vga_y == 9'(TICK_Y));
    assign tick      = at_tick && !at_tick_q;

    // Geometry is evaluated on the pre-step position, so a hit in a step cycle uses the old boxes.
    always_comb begin
        for (int i = 0; i < 5; i++) begin
            y_lo[i]     = $signed({3'b000, sy}) + $signed({2'b00, yoff_q})
                          + $signed(12'(i * ROW_PITCH));
            hit_vec[i]  = alive_q[i] && bullet_on && (bx_s >= x_lo) && (bx_s <= x_hi)
                          && (by_s >= y_lo[i]) && (by_s <= y_lo[i] + H_M1);
            scan_vec[i] = alive_q[i] && (vx_s >= x_lo) && (vx_s <= x_hi)
                          && (vy_s >= y_lo[i]) && (vy_s <= y_lo[i] + H_M1)
`ifdef ENEMY_SPRITE_EN
                          && (|(sprite_row((i == 0) ? 2'd0 : ((i < 3) ? 2'd1 : 2'd2), anim_q,
                                           3'(vy_s - y_lo[i])) & (11'd1 << 4'(vx_s - x_lo))))
`endif
                          ;
            low_vec[i]  = alive_q[i] && (y_lo[i] + H_M1 >= GG_S);
        end
    end

    always_comb begin
        xoff_d     = xoff_q;
        yoff_d     = yoff_q;
        dir_left_d = dir_left_q;
        alive_d    = alive_q;
        fcnt_d     = fcnt_q;
        score_d    = score_q;
        move_d     = 1'b0;
        b_hit_d    = |hit_vec;
        pixel_d    = |scan_vec;
        gg_d       = gg_q | (|low_vec);
`ifdef ENEMY_SPRITE_EN
        anim_d     = anim_q;
`endif
        if (tick) begin
            if (fcnt_q == FC_LAST) begin
                fcnt_d = '0;
                move_d = 1'b1;
`ifdef ENEMY_SPRITE_EN
                anim_d = ~anim_q;
`endif
                if (!dir_left_q) begin
                    if (right_in) begin
                        yoff_d     = yoff_q + DROP_U;
                        dir_left_d = 1'b1;
                    end else begin
                        xoff_d = xoff_q + STEP_S;
                    end
                end else begin
                    if (left_in) begin
                        yoff_d     = yoff_q + DROP_U;
                        dir_left_d = 1'b0;
                    end else begin
                        xoff_d = xoff_q - STEP_S;
                    end
                end
            end else begin
                fcnt_d = fcnt_q + FW'(1);
            end
        end
        for (int i = 0; i < 5; i++) begin
            if (hit_vec[i]) begin
                alive_d[i] = 1'b0;
                score_d    = score_q + row_points(i);
            end
        end
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            xoff_q     <= '0;
            yoff_q     <= '0;
            dir_left_q <= 1'b0;
            alive_q    <= 5'b11111;
            fcnt_q     <= '0;
            score_q    <= '0;
            at_tick_q  <= 1'b0;
            b_hit_q    <= 1'b0;
            move_q     <= 1'b0;
            pixel_q    <= 1'b0;
            gg_q       <= 1'b0;
`ifdef ENEMY_SPRITE_EN
            anim_q     <= 1'b0;
`endif
        end else begin
            xoff_q     <= xoff_d;
            yoff_q     <= yoff_d;
            dir_left_q <= dir_left_d;
            alive_q    <= alive_d;
            fcnt_q     <= fcnt_d;
            score_q    <= score_d;
            at_tick_q  <= at_tick;
            b_hit_q    <= b_hit_d;
            move_q     <= move_d;
            pixel_q    <= pixel_d;
            gg_q       <= gg_d;
`ifdef ENEMY_SPRITE_EN
            anim_q     <= anim_d;
`endif
        end
    end

    assign right = any_alive && !dir_left_q && (x_hi + STEP_S > RLIM_S);
    assign left  = any_alive && dir_left_q && (x_lo < LLIM_S);
    assign b_hit = b_hit_q;
    assign move  = move_q;
    assign pixel = pixel_q;
    assign score = score_q;
    assign gg    = gg_q;

endmodule

// File: tb/tb_enemy_column.sv
// Bench for enemy_column (default solid-box build): directed scenarios plus randomized traffic
// checked every cycle against a behavioural model of the formation.
module tb_enemy_column;
    logic        clk = 1'b0;
    logic        reset;
    logic        left_in, right_in;
    logic [9:0]  sx, vga_x, bx;
    logic [8:0]  sy, vga_y, by;
    logic        left, right, b_hit, move, pixel, gg;
    logic [10:0] score;

    int n_checks = 0;
    int n_errors = 0;
    int n_moves  = 0;

    // Behavioural model of the column
    int m_x, m_y, m_fc, m_score;
    bit m_dir_left, m_gg, m_prev_at;
    bit m_alive[5];
    int row_pts[5] = '{30, 20, 20, 10, 10};

    always #5 clk = ~clk;

    enemy_column dut (
        .clk(clk), .reset(reset), .left_in(left_in), .right_in(right_in),
        .sx(sx), .sy(sy), .vga_x(vga_x), .vga_y(vga_y), .bx(bx), .by(by),
        .left(left), .right(right), .b_hit(b_hit), .move(move),
        .pixel(pixel), .score(score), .gg(gg)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    function automatic bit in_box(input int px, input int py, input int row);
        int ox, oy;
        ox = int'(sx) + m_x;
        oy = int'(sy) + m_y + 12 * row;
        return (px >= ox) && (px <= ox + 10) && (py >= oy) && (py <= oy + 7);
    endfunction

    function automatic bit m_any();
        bit a = 0;
        for (int i = 0; i < 5; i++) a |= m_alive[i];
        return a;
    endfunction

    function automatic bit m_right();
        return m_any() && !m_dir_left && (int'(sx) + m_x + 10 + 2 > 317);
    endfunction

    function automatic bit m_left();
        return m_any() && m_dir_left && (int'(sx) + m_x < 4);
    endfunction

    function automatic void model_reset();
        m_x = 0; m_y = 0; m_fc = 0; m_score = 0;
        m_dir_left = 0; m_gg = 0; m_prev_at = 0;
        for (int i = 0; i < 5; i++) m_alive[i] = 1;
    endfunction

    // One clock: predict from current inputs and pre-edge model state, then compare after the edge.
    task automatic cycle();
        int hit = -1;
        bit pix = 0;
        bit mv = 0;
        bit ggn, at, tk, bul;
        bul = !(bx == 0 && by == 0);
        ggn = m_gg;
        for (int i = 0; i < 5; i++) begin
            if (m_alive[i] && bul && in_box(int'(bx), int'(by), i)) hit = i;
            if (m_alive[i] && in_box(int'(vga_x), int'(vga_y), i)) pix = 1;
            if (m_alive[i] && int'(sy) + m_y + 12 * i + 7 >= 200) ggn = 1;
        end
        at = (vga_x == 240) && (vga_y == 180);
        tk = at && !m_prev_at;
        m_prev_at = at;
        if (tk) begin
            if (m_fc == 7) begin
                m_fc = 0;
                mv = 1;
                if (!m_dir_left) begin
                    if (right_in) begin m_y += 8; m_dir_left = 1; end
                    else m_x += 2;
                end else begin
                    if (left_in) begin m_y += 8; m_dir_left = 0; end
                    else m_x -= 2;
                end
            end else begin
                m_fc++;
            end
        end
        if (hit >= 0) begin
            m_alive[hit] = 0;
            m_score += row_pts[hit];
        end
        m_gg = ggn;
        @(posedge clk);
        #1;
        if (mv) n_moves++;
        check("b_hit", b_hit, 32'(hit >= 0));
        check("move", move, 32'(mv));
        check("pixel", pixel, 32'(pix));
        check("score", score, 32'(m_score));
        check("gg", gg, 32'(m_gg));
        check("right", right, 32'(m_right()));
        check("left", left, 32'(m_left()));
    endtask

    task automatic do_reset();
        reset = 1'b0;
        #1;
        model_reset();
        check("rst_score", score, 0);
        check("rst_b_hit", b_hit, 0);
        check("rst_move", move, 0);
        check("rst_pixel", pixel, 0);
        check("rst_gg", gg, 0);
        check("rst_left", left, 0);
        check("rst_right", right, 0);
        @(posedge clk);
        @(posedge clk);
        #1;
        reset = 1'b1;
    endtask

    task automatic set_scan(input int x, input int y);
        vga_x = 10'(x);
        vga_y = 9'(y);
    endtask

    task automatic tick_once();
        set_scan(240, 180); cycle();
        set_scan(0, 0);     cycle();
    endtask

    initial begin
        reset = 1'b0;
        left_in = 0; right_in = 0;
        sx = 10'd5; sy = 9'd8;
        vga_x = 0; vga_y = 0; bx = 0; by = 0;
        #2;
        do_reset();

        // Initial scan: column at x 5..15, rows 8..15 and 20..27
        for (int y = 8; y <= 19; y++)
            for (int x = 8; x <= 39; x++) begin
                set_scan(x, y);
                cycle();
                check("scan_spec", pixel, 32'((x <= 15) && (y <= 15)));
            end

        // Top-row kill, then hold the bullet
        bx = 10; by = 10;
        cycle();
        check("hit_top_pulse", b_hit, 1);
        check("hit_top_score", score, 30);
        for (int k = 0; k < 3; k++) begin
            cycle();
            check("no_rehit", b_hit, 0);
        end
        bx = 0; by = 0;
        for (int y = 8; y <= 15; y++) begin
            set_scan(10, y);
            cycle();
            check("dead_row0", pixel, 0);
        end

        bx = 10; by = 58;
        cycle();
        check("hit_row4_score", score, 40);
        bx = 10; by = 22;
        cycle();
        check("hit_row1_score", score, 60);
        bx = 0; by = 0;
        cycle();

        // Eight ticks step the formation right by 2
        n_moves = 0;
        for (int k = 0; k < 8; k++) tick_once();
        check("one_move", n_moves, 1);
        set_scan(6, 34);  cycle(); check("shift_left_edge", pixel, 0);
        set_scan(17, 34); cycle(); check("shift_right_edge", pixel, 1);

        // Long hold at the tick point is one tick; then seven more with right_in to drop
        n_moves = 0;
        set_scan(240, 180);
        for (int k = 0; k < 20; k++) cycle();
        set_scan(0, 0); cycle();
        check("hold_no_move", n_moves, 0);
        right_in = 1;
        for (int k = 0; k < 7; k++) tick_once();
        right_in = 0;
        check("drop_move", n_moves, 1);
        set_scan(10, 40); cycle(); check("drop_row2_top", pixel, 1);
        set_scan(10, 39); cycle(); check("drop_above_row2", pixel, 0);
        for (int k = 0; k < 8; k++) tick_once();
        set_scan(5, 40);  cycle(); check("left_step_lo", pixel, 1);
        set_scan(16, 40); cycle(); check("left_step_hi", pixel, 0);

        // Kill the remaining rows 2 and 3
        bx = 10; by = 41; cycle();
        bx = 10; by = 53; cycle();
        bx = 0; by = 0; cycle();
        check("all_dead_score", score, 90);
        check("all_dead_left", left, 0);
        check("all_dead_right", right, 0);
        for (int y = 40; y <= 60; y += 4) begin
            set_scan(8, y);
            cycle();
            check("all_dead_pixel", pixel, 0);
        end

        // Mid-game reset
        for (int k = 0; k < 5; k++) tick_once();
        do_reset();

        // Both edge inputs held: every step drops until a live enemy reaches the floor
        left_in = 1; right_in = 1;
        for (int k = 0; k < 240; k++) tick_once();
        check("gg_set", gg, 1);
        left_in = 0; right_in = 0;
        for (int k = 0; k < 4; k++) cycle();
        check("gg_sticky", gg, 1);

        // Randomized traffic over several column positions
        for (int r = 0; r < 4; r++) begin
            sx = 10'(5 + 15 * $urandom_range(0, 10));
            do_reset();
            for (int k = 0; k < 1200; k++) begin
                if ($urandom_range(0, 9) < 3) set_scan(240, 180);
                else set_scan(int'(sx) - 5 + $urandom_range(0, 200), $urandom_range(0, 230));
                if ($urandom_range(0, 19) == 0) begin
                    bx = 10'(int'(sx) - 3 + $urandom_range(0, 180));
                    by = 9'($urandom_range(0, 120));
                end else begin
                    bx = 0; by = 0;
                end
                right_in = m_right() | ($urandom_range(0, 19) == 0);
                left_in  = m_left()  | ($urandom_range(0, 19) == 0);
                cycle();
            end
        end

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end
endmodule
